// File: rtl/definitions_pkg.sv
// Shared types and constants for the counter checker.
// Holds the FSM state type and the default counter width.
package definitions_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } chk_state_t;

endpackage

// File: rtl/cnt_model.sv
// Reference model of the observed up/down counter.
// Predicts the next value and whether that step wraps.
module cnt_model
  import definitions_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic             i_load_en,
  input  logic [WIDTH-1:0] i_load,
  input  logic             i_down,
  input  logic [WIDTH-1:0] i_cur,
  output logic [WIDTH-1:0] o_next,
  output logic             o_roll
);

  always_comb begin
    o_next = i_down ? (i_cur - WIDTH'(1)) : (i_cur + WIDTH'(1));
    if (i_load_en) begin
      o_next = i_load;
    end
    // A load always wins over a wrap.
    o_roll = !i_load_en && (i_down ? (i_cur == '0) : (i_cur == '1));
  end

endmodule

// File: rtl/cnt_checker.sv
// Passive checker for an up/down counter with load and rollover flag.
// Tracks the counter with cnt_model and records mismatches and statistics.
module cnt_checker
  import definitions_pkg::*;
#(
  parameter int unsigned WIDTH       = CNT_W,
  parameter int unsigned ERR_W       = 8,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_dut_rstn,
  input  logic             i_load_en,
  input  logic [WIDTH-1:0] i_load,
  input  logic             i_down,
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_rollover,
  output logic [WIDTH-1:0] o_exp_count,
  output logic             o_mismatch,
  output logic             o_err_sticky,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic [ERR_W-1:0] o_chk_cnt,
  output chk_state_t       o_state
);

  chk_state_t       r_state;
  logic [WIDTH-1:0] r_exp_count;
  logic             r_exp_roll;
  logic             r_mismatch;
  logic             r_err_sticky;
  logic             r_need_zero;
  logic [ERR_W-1:0] r_err_cnt;
  logic [ERR_W-1:0] r_chk_cnt;

  logic             w_active;
  logic [WIDTH-1:0] w_seed;
  logic [WIDTH-1:0] w_next;
  logic             w_roll;
  logic             w_cmp_fail;

  assign w_active = i_enable && i_dut_rstn;

  // SYNC seeds the model from the counter's reset value after a counter or checker
  // reset, otherwise from whatever the counter currently shows.
  assign w_seed = (r_state == SYNC) ? (r_need_zero ? '0 : i_count) : r_exp_count;

  cnt_model #(
    .WIDTH(WIDTH)
  ) u_model (
    .i_load_en(i_load_en),
    .i_load   (i_load),
    .i_down   (i_down),
    .i_cur    (w_seed),
    .o_next   (w_next),
    .o_roll   (w_roll)
  );

  always_comb begin
    w_cmp_fail = 1'b0;
    if (r_state == SYNC) begin
      w_cmp_fail = r_need_zero && (i_count != '0);
    end else if (r_state == CHECK) begin
      w_cmp_fail = (i_count != r_exp_count) || (i_rollover != r_exp_roll);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_exp_count  <= '0;
      r_exp_roll   <= 1'b0;
      r_mismatch   <= 1'b0;
      r_err_sticky <= 1'b0;
      r_need_zero  <= 1'b1;
      r_err_cnt    <= '0;
      r_chk_cnt    <= '0;
    end else begin
      r_mismatch <= 1'b0;
      if (!i_dut_rstn) begin
        r_need_zero <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_active) begin
            r_state <= SYNC;
          end
        end
        SYNC, CHECK: begin
          // Leaving on a counter reset or disable skips the comparison entirely.
          if (!w_active) begin
            r_state <= IDLE;
          end else begin
            r_exp_count <= w_next;
            r_exp_roll  <= w_roll;
            if (r_state == SYNC) begin
              r_need_zero <= 1'b0;
              r_state     <= CHECK;
            end else if (r_chk_cnt != '1) begin
              r_chk_cnt <= r_chk_cnt + ERR_W'(1);
            end
            if (w_cmp_fail) begin
              r_mismatch   <= 1'b1;
              r_err_sticky <= 1'b1;
              if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
              end
              if (STOP_ON_ERR) begin
                r_state <= HALT;
              end
            end
          end
        end
        HALT: begin
          r_state <= HALT;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_exp_count  = r_exp_count;
  assign o_mismatch   = r_mismatch;
  assign o_err_sticky = r_err_sticky;
  assign o_err_cnt    = r_err_cnt;
  assign o_chk_cnt    = r_chk_cnt;
  assign o_state      = r_state;

endmodule

// File: tb/tb_cnt_checker.sv
// Directed bench for cnt_checker: a behavioural counter drives three checker
// variants (default, stop-on-error, 2-bit statistics) with planted faults.
module tb_cnt_checker;
  import definitions_pkg::*;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst, enable, dut_rstn, load_en, down, rollover;
  logic [W-1:0] load, count;

  logic [W-1:0] a_exp, h_exp, s_exp;
  logic         a_mm, h_mm, s_mm, a_stk, h_stk, s_stk;
  logic [7:0]   a_err, a_chk, h_err, h_chk;
  logic [1:0]   s_err, s_chk;
  chk_state_t   a_st, h_st, s_st;

  // Behavioural counter state and fault masks.
  logic [W-1:0] cnt, fault;
  logic         roll, rfault, cen;
  int           n_chk, h_frozen;
  int           n_checks = 0;
  int           n_errors = 0;
  bit           exp_q[$];

  always #5 clk = ~clk;

  cnt_checker u_dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_dut_rstn(dut_rstn),
    .i_load_en(load_en), .i_load(load), .i_down(down), .i_count(count),
    .i_rollover(rollover), .o_exp_count(a_exp), .o_mismatch(a_mm),
    .o_err_sticky(a_stk), .o_err_cnt(a_err), .o_chk_cnt(a_chk), .o_state(a_st)
  );

  cnt_checker #(.STOP_ON_ERR(1'b1)) u_halt (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_dut_rstn(dut_rstn),
    .i_load_en(load_en), .i_load(load), .i_down(down), .i_count(count),
    .i_rollover(rollover), .o_exp_count(h_exp), .o_mismatch(h_mm),
    .o_err_sticky(h_stk), .o_err_cnt(h_err), .o_chk_cnt(h_chk), .o_state(h_st)
  );

  cnt_checker #(.ERR_W(2)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_dut_rstn(dut_rstn),
    .i_load_en(load_en), .i_load(load), .i_down(down), .i_count(count),
    .i_rollover(rollover), .o_exp_count(s_exp), .o_mismatch(s_mm),
    .o_err_sticky(s_stk), .o_err_cnt(s_err), .o_chk_cnt(s_chk), .o_state(s_st)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    count    = cnt ^ fault;
    rollover = roll ^ rfault;
  endtask

  // One clock: queue the expected mismatch for this sample, advance the counter,
  // then compare the pulse the checker produced for it.
  task automatic tick(input bit chk, input bit mm);
    exp_q.push_back(mm);
    @(posedge clk);
    #1;
    if (!dut_rstn) begin
      cnt  = '0;
      roll = 1'b0;
    end else if (cen) begin
      if (load_en) begin
        cnt  = load;
        roll = 1'b0;
      end else if (down) begin
        roll = (cnt == 4'h0);
        cnt  = cnt - 4'd1;
      end else begin
        roll = (cnt == 4'hF);
        cnt  = cnt + 4'd1;
      end
    end else begin
      roll = 1'b0;
    end
    if (rst) n_chk = 0;
    else     n_chk += int'(chk);
    drive();
    check("mismatch", 32'(a_mm), 32'(exp_q.pop_front()));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b0; dut_rstn = 1'b0; load_en = 1'b0; load = '0; down = 1'b0;
    cnt = '0; roll = 1'b0; fault = '0; rfault = 1'b0; cen = 1'b0; n_chk = 0; h_frozen = 0;
    drive();
    tick(0, 0);
    tick(0, 0);
    check("rst_state", 32'(a_st), 32'(IDLE));
    check("rst_exp", 32'(a_exp), 32'(0));
    check("rst_sticky", 32'(a_stk), 32'(0));
    check("rst_err", 32'(a_err), 32'(0));
    check("rst_chk", 32'(a_chk), 32'(0));

    // Up count from reset through a wrap.
    rst = 1'b0; enable = 1'b1; dut_rstn = 1'b1;
    tick(0, 0);
    check("sync_state", 32'(a_st), 32'(SYNC));
    cen = 1'b1;
    tick(0, 0);
    check("check_state", 32'(a_st), 32'(CHECK));
    check("first_exp", 32'(a_exp), 32'(cnt));
    for (int i = 0; i < 20; i++) begin
      tick(1, 0);
      check("up_exp", 32'(a_exp), 32'(cnt));
    end
    check("up_chk", 32'(a_chk), 32'(20));
    check("up_err", 32'(a_err), 32'(0));
    check("sat_chk", 32'(s_chk), 32'(3));

    // Down count wrapping below zero.
    load_en = 1'b1; load = 4'h0;
    tick(1, 0);
    check("load0_exp", 32'(a_exp), 32'(4'h0));
    load_en = 1'b0; down = 1'b1;
    tick(1, 0);
    check("down_wrap", 32'(a_exp), 32'(4'hF));
    tick(1, 0);
    check("down_next", 32'(a_exp), 32'(4'hE));
    check("down_err", 32'(a_err), 32'(0));

    // Load of all-ones does not roll; the following increment does.
    down = 1'b0; load_en = 1'b1; load = 4'hF;
    tick(1, 0);
    check("loadF_exp", 32'(a_exp), 32'(4'hF));
    load_en = 1'b0;
    tick(1, 0);
    check("loadF_wrap", 32'(a_exp), 32'(4'h0));
    tick(1, 0);

    // Forced count fault: 5 shown where 4 is expected.
    load_en = 1'b1; load = 4'h4;
    tick(1, 0);
    load_en = 1'b0; fault = 4'h1; drive();
    tick(1, 1);
    fault = '0; drive();
    h_frozen = n_chk;
    check("fault_sticky", 32'(a_stk), 32'(1));
    check("fault_err", 32'(a_err), 32'(1));
    check("halt_state", 32'(h_st), 32'(HALT));
    check("halt_mm", 32'(h_mm), 32'(1));
    check("halt_chk", 32'(h_chk), 32'(h_frozen));
    tick(1, 0);
    tick(1, 0);
    check("halt_frozen", 32'(h_chk), 32'(h_frozen));
    check("halt_mm_low", 32'(h_mm), 32'(0));
    check("fault_exp", 32'(a_exp), 32'(cnt));

    // Rollover flag raised when no wrap is due.
    rfault = 1'b1; drive();
    tick(1, 1);
    rfault = 1'b0; drive();
    check("roll_err", 32'(a_err), 32'(2));
    tick(1, 0);

    // Counter reset mid-check, then release.
    dut_rstn = 1'b0;
    tick(0, 0);
    check("rstn_idle", 32'(a_st), 32'(IDLE));
    dut_rstn = 1'b1; cen = 1'b0;
    tick(0, 0);
    check("rstn_sync", 32'(a_st), 32'(SYNC));
    cen = 1'b1;
    tick(0, 0);
    check("rstn_check", 32'(a_st), 32'(CHECK));
    check("rstn_exp", 32'(a_exp), 32'(cnt));
    tick(1, 0);
    check("rstn_err", 32'(a_err), 32'(2));
    check("halt_hold", 32'(h_st), 32'(HALT));

    // Enable toggle resyncs to a non-zero count.
    enable = 1'b0;
    tick(0, 0);
    check("en_idle", 32'(a_st), 32'(IDLE));
    enable = 1'b1;
    tick(0, 0);
    check("en_sync", 32'(a_st), 32'(SYNC));
    tick(0, 0);
    check("en_exp", 32'(a_exp), 32'(cnt));
    tick(1, 0);
    check("en_chk", 32'(a_chk), 32'(n_chk));
    check("en_err", 32'(a_err), 32'(2));

    // Checker reset, then a bad sync value and four bad check samples.
    rst = 1'b1; enable = 1'b0; load_en = 1'b1; load = 4'h0;
    tick(0, 0);
    check("rst2_state", 32'(a_st), 32'(IDLE));
    check("rst2_halt", 32'(h_st), 32'(IDLE));
    check("rst2_sticky", 32'(a_stk), 32'(0));
    check("rst2_err", 32'(a_err), 32'(0));
    check("rst2_chk", 32'(a_chk), 32'(0));
    rst = 1'b0; load_en = 1'b0; cen = 1'b0; fault = 4'h2; enable = 1'b1; drive();
    tick(0, 0);
    cen = 1'b1;
    tick(0, 1);
    for (int i = 0; i < 4; i++) tick(1, 1);
    fault = '0; drive();
    check("sat_err", 32'(s_err), 32'(3));
    check("sat_chk2", 32'(s_chk), 32'(3));
    check("sat_sticky", 32'(s_stk), 32'(1));
    check("full_err", 32'(a_err), 32'(5));
    check("full_chk", 32'(a_chk), 32'(n_chk));
    rst = 1'b1;
    tick(0, 0);
    check("clr_err", 32'(s_err), 32'(0));
    check("clr_chk", 32'(s_chk), 32'(0));
    check("clr_sticky", 32'(s_stk), 32'(0));
    check("clr_mm", 32'(s_mm), 32'(0));
    check("clr_exp", 32'(s_exp), 32'(0));
    check("clr_state", 32'(s_st), 32'(IDLE));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
